// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures an exception, interrupt or MRET, flushes
// the pipeline, writes the trap CSRs (or commits MRET) and redirects fetch.
module trap_ctrl #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              exc_valid_i,
    input  logic [CAUSE_W-1:0] exc_cause_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic [XLEN-1:0]   exc_tval_i,
    input  logic              mret_i,
    input  logic              irq_i,
    input  logic              mstatus_mie_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    input  logic              pipe_empty_i,
    input  logic              redirect_ready_i,
    output logic              busy_o,
    output logic              flush_o,
    output logic              trap_we_o,
    output logic [XLEN-1:0]   mepc_wdata_o,
    output logic [XLEN-1:0]   mcause_wdata_o,
    output logic [XLEN-1:0]   mtval_wdata_o,
    output logic              mret_commit_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, WRITE, REDIRECT} state_t;

    // Machine external interrupt, cause code 11, interrupt bit set.
    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-5){1'b0}}, 4'd11};

    state_t          state_reg, state_next;
    logic            ret_reg;
    logic [XLEN-1:0] pc_reg, cause_reg, tval_reg, target_reg;
    logic [XLEN-1:0] trap_base, trap_target;
    logic            irq_take, event_take;

    assign irq_take   = irq_i & mstatus_mie_i;
    assign event_take = exc_valid_i | mret_i | irq_take;

    assign trap_base   = {mtvec_i[XLEN-1:2], 2'b00};
    // Vectored mode only offsets interrupts; the offset wraps modulo 2^XLEN.
    assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_reg[XLEN-1])
                         ? trap_base + {cause_reg[XLEN-3:0], 2'b00}
                         : trap_base;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (event_take) state_next = FLUSH;
            FLUSH:    if (pipe_empty_i) state_next = WRITE;
            WRITE:    state_next = REDIRECT;
            REDIRECT: if (redirect_ready_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            ret_reg    <= 1'b0;
            pc_reg     <= '0;
            cause_reg  <= '0;
            tval_reg   <= '0;
            target_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                if (exc_valid_i) begin
                    ret_reg   <= 1'b0;
                    pc_reg    <= exc_pc_i;
                    tval_reg  <= exc_tval_i;
                    cause_reg <= {{(XLEN-CAUSE_W){1'b0}}, exc_cause_i};
                end else if (mret_i) begin
                    ret_reg   <= 1'b1;
                    pc_reg    <= {mepc_i[XLEN-1:2], 2'b00};
                    tval_reg  <= '0;
                    cause_reg <= '0;
                end else if (irq_take) begin
                    ret_reg   <= 1'b0;
                    pc_reg    <= exc_pc_i;
                    tval_reg  <= '0;
                    cause_reg <= IRQ_CAUSE;
                end
            end
            // mtvec is sampled here so the target stays fixed during the stall.
            if (state_reg == WRITE)
                target_reg <= ret_reg ? pc_reg : trap_target;
        end
    end

    assign busy_o           = (state_reg != IDLE);
    assign flush_o          = (state_reg == FLUSH);
    assign trap_we_o        = (state_reg == WRITE) && !ret_reg;
    assign mret_commit_o    = (state_reg == WRITE) &&  ret_reg;
    assign redirect_valid_o = (state_reg == REDIRECT);
    assign redirect_pc_o    = target_reg;
    assign mepc_wdata_o     = pc_reg;
    assign mcause_wdata_o   = cause_reg;
    assign mtval_wdata_o    = tval_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a driver pushes expected CSR writes and
// redirects, a negedge monitor pops and compares them as the DUT emits them.
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        exc_valid_i, mret_i, irq_i, mstatus_mie_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, mtvec_i, mepc_i;
    logic        pipe_empty_i, redirect_ready_i;
    logic        busy_o, flush_o, trap_we_o, mret_commit_o, redirect_valid_o;
    logic [31:0] mepc_wdata_o, mcause_wdata_o, mtval_wdata_o, redirect_pc_o;

    trap_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .irq_i(irq_i), .mstatus_mie_i(mstatus_mie_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .pipe_empty_i(pipe_empty_i), .redirect_ready_i(redirect_ready_i),
        .busy_o(busy_o), .flush_o(flush_o), .trap_we_o(trap_we_o),
        .mepc_wdata_o(mepc_wdata_o), .mcause_wdata_o(mcause_wdata_o),
        .mtval_wdata_o(mtval_wdata_o), .mret_commit_o(mret_commit_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        bit          ret;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] rpc;
        bit          wseen;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   txn_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: priority exc > mret > enabled irq; trap target from mtvec.
    function automatic bit model(input bit exc, input bit mret, input bit irq, input bit mie,
                                 input logic [3:0] cause, input logic [31:0] pc,
                                 input logic [31:0] tval, input logic [31:0] mtvec,
                                 input logic [31:0] mepc, output exp_t e);
        logic [31:0] base;
        e    = '0;
        base = mtvec & ~32'h3;
        if (exc) begin
            e.mepc = pc; e.mcause = {28'd0, cause}; e.mtval = tval; e.rpc = base;
            return 1'b1;
        end
        if (mret) begin
            e.ret = 1'b1; e.rpc = mepc & ~32'h3;
            return 1'b1;
        end
        if (irq && mie) begin
            e.mepc = pc; e.mcause = 32'h8000000B; e.mtval = 32'd0;
            e.rpc = (mtvec % 4 == 1) ? base + 32'd44 : base;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (trap_we_o || mret_commit_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    check("trap_we", {31'd0, trap_we_o}, {31'd0, !exp_q[0].ret});
                    check("mret_commit", {31'd0, mret_commit_o}, {31'd0, exp_q[0].ret});
                    if (!exp_q[0].ret) begin
                        check("mepc_wdata", mepc_wdata_o, exp_q[0].mepc);
                        check("mcause_wdata", mcause_wdata_o, exp_q[0].mcause);
                        check("mtval_wdata", mtval_wdata_o, exp_q[0].mtval);
                    end
                    exp_q[0].wseen = 1'b1;
                end
            end
            if (redirect_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    check("redirect_pc", redirect_pc_o, exp_q[0].rpc);
                    if (redirect_ready_i) begin
                        check("write_before_redirect", {31'd0, exp_q[0].wseen}, 32'd1);
                        $display("[TB] txn %0d done ret=%0d pc=0x%08h", txn_id, exp_q[0].ret, redirect_pc_o);
                        txn_id++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Called #1 after a posedge with the DUT idle; drives one event cycle.
    task automatic issue(input bit exc, input bit mret, input bit irq, input bit mie,
                         input logic [3:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                         input logic [31:0] mtvec, input logic [31:0] mepc, output bit acc);
        exp_t e;
        exc_valid_i = exc; mret_i = mret; irq_i = irq; mstatus_mie_i = mie;
        exc_cause_i = cause; exc_pc_i = pc; exc_tval_i = tval; mtvec_i = mtvec; mepc_i = mepc;
        acc = model(exc, mret, irq, mie, cause, pc, tval, mtvec, mepc, e);
        if (acc) exp_q.push_back(e);
        @(posedge clk_i); #1;
        exc_valid_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0;
    endtask

    task automatic run_txn(input int pe_low, input int rdy_low, input bit noise);
        int n = 0;
        int rv = 0;
        int flush_cnt = 0;
        int lat = -1;
        bit done = 1'b0;
        while (!done && n < 100) begin
            pipe_empty_i     = (n >= pe_low);
            redirect_ready_i = (rv >= rdy_low);
            if (noise) begin
                exc_valid_i = 1'($urandom_range(0, 1));
                mret_i      = 1'($urandom_range(0, 1));
                irq_i       = 1'($urandom_range(0, 1));
                exc_cause_i = 4'($urandom);
                exc_pc_i    = $urandom;
            end
            @(negedge clk_i);
            check("busy_in_txn", {31'd0, busy_o}, 32'd1);
            if (flush_o) flush_cnt++;
            if (redirect_valid_o) begin
                if (lat < 0) lat = n + 1;
                rv++;
            end
            done = redirect_valid_o && redirect_ready_i;
            @(posedge clk_i); #1;
            n++;
        end
        exc_valid_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0;
        if (!done) check("txn_timeout", 32'd0, 32'd1);
        check("flush_cycles", flush_cnt, pe_low + 1);
        check("latency", lat, pe_low + 3);
        check("busy_after_handshake", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic expect_idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk_i);
            check("idle_busy", {31'd0, busy_o}, 32'd0);
            check("idle_flush", {31'd0, flush_o}, 32'd0);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
        check({tag, "_trap_we"}, {31'd0, trap_we_o}, 32'd0);
        check({tag, "_mret"}, {31'd0, mret_commit_o}, 32'd0);
        check({tag, "_rvalid"}, {31'd0, redirect_valid_o}, 32'd0);
        check({tag, "_rpc"}, redirect_pc_o, 32'd0);
        check({tag, "_mepc"}, mepc_wdata_o, 32'd0);
        check({tag, "_mcause"}, mcause_wdata_o, 32'd0);
        check({tag, "_mtval"}, mtval_wdata_o, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_n_i = 1'b0;
        exc_valid_i = 0; mret_i = 0; irq_i = 0; mstatus_mie_i = 0;
        exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0; mtvec_i = 0; mepc_i = 0;
        pipe_empty_i = 1; redirect_ready_i = 1;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Exception with immediate drain and ready.
        issue(1, 0, 0, 0, 4'd2, 32'h100, 32'hDEAD, 32'h800, 32'h0, acc);
        check("exc_accepted", {31'd0, acc}, 32'd1);
        run_txn(0, 0, 0);

        // Vectored interrupt, then masked interrupt.
        issue(0, 0, 1, 1, 4'd0, 32'h40, 32'h0, 32'h801, 32'h0, acc);
        run_txn(0, 0, 0);
        issue(0, 0, 1, 0, 4'd0, 32'h40, 32'h0, 32'h801, 32'h0, acc);
        check("masked_irq_ignored", {31'd0, acc}, 32'd0);
        expect_idle(3);

        // Exception beats MRET; then MRET alone.
        issue(1, 1, 0, 0, 4'd5, 32'h300, 32'h1234, 32'h900, 32'h203, acc);
        run_txn(0, 0, 0);
        issue(0, 1, 0, 0, 4'd0, 32'h0, 32'h0, 32'h900, 32'h203, acc);
        run_txn(0, 0, 0);

        // Slow drain and stalled fetch.
        issue(1, 0, 0, 0, 4'd7, 32'h500, 32'h77, 32'hA00, 32'h0, acc);
        run_txn(4, 4, 0);

        // Events during busy are ignored; back-to-back accept right after handshake.
        issue(1, 0, 0, 0, 4'd1, 32'h600, 32'h11, 32'hB00, 32'h0, acc);
        run_txn(1, 2, 1);
        issue(1, 0, 0, 0, 4'd3, 32'h604, 32'h22, 32'hB00, 32'h0, acc);
        run_txn(0, 0, 1);

        // Reset in WRITE.
        issue(1, 0, 0, 0, 4'd4, 32'h700, 32'h33, 32'hC00, 32'h0, acc);
        pipe_empty_i = 1'b1; redirect_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b0; #1;
        check_all_zero("rst_write");
        exp_q.delete();
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        expect_idle(4);

        // Reset in REDIRECT.
        issue(0, 0, 1, 1, 4'd0, 32'h710, 32'h0, 32'hC01, 32'h0, acc);
        pipe_empty_i = 1'b1; redirect_ready_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("in_redirect", {31'd0, redirect_valid_o}, 32'd1);
        rst_n_i = 1'b0; #1;
        check_all_zero("rst_redirect");
        exp_q.delete();
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        expect_idle(4);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            issue(sel < 4, (sel >= 3 && sel < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom), $urandom, $urandom, $urandom, $urandom, acc);
            if (acc) run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else expect_idle(1);
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
